// File: rtl/alu_share_arbiter.sv
// Two-port round-robin front end to one shared 16-bit ALU, with a single-entry
// registered response buffer and the architectural N/Z/V flag register.

module alu16 (
  input  logic [2:0]  op_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] res_o,
  output logic [2:0]  flags_o
);
  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_RED    = 3'd3;
  localparam logic [2:0] OP_SLL    = 3'd4;
  localparam logic [2:0] OP_SRA    = 3'd5;
  localparam logic [2:0] OP_ROR    = 3'd6;
  localparam logic [2:0] OP_PADDSB = 3'd7;

  logic [15:0] res;
  logic        n_flag;
  logic        v_flag;
  logic [4:0]  nib_sum;

  // N and V are only produced by ADD/SUB; every other op reports them as 0.
  always_comb begin
    res     = '0;
    n_flag  = 1'b0;
    v_flag  = 1'b0;
    nib_sum = '0;
    case (op_i)
      OP_ADD: begin
        res    = a_i + b_i;
        n_flag = res[15];
        v_flag = (a_i[15] == b_i[15]) && (res[15] != a_i[15]);
      end
      OP_SUB: begin
        res    = a_i - b_i;
        n_flag = res[15];
        v_flag = (a_i[15] != b_i[15]) && (res[15] != a_i[15]);
      end
      OP_XOR: res = a_i ^ b_i;
      OP_RED: res = {{8{a_i[15]}}, a_i[15:8]} + {{8{a_i[7]}}, a_i[7:0]}
                  + {{8{b_i[15]}}, b_i[15:8]} + {{8{b_i[7]}}, b_i[7:0]};
      OP_SLL: res = a_i << b_i[3:0];
      OP_SRA: res = 16'($signed(a_i) >>> b_i[3:0]);
      OP_ROR: res = 16'({a_i, a_i} >> b_i[3:0]);
      OP_PADDSB: begin
        // Four independent signed nibble adds, saturated to [-8, 7].
        for (int i = 0; i < 4; i++) begin
          nib_sum = {a_i[4*i+3], a_i[4*i +: 4]} + {b_i[4*i+3], b_i[4*i +: 4]};
          if (nib_sum[4] != nib_sum[3]) res[4*i +: 4] = nib_sum[4] ? 4'h8 : 4'h7;
          else                          res[4*i +: 4] = nib_sum[3:0];
        end
      end
      default: res = '0;
    endcase
    res_o   = res;
    flags_o = {n_flag, (res == 16'h0000), v_flag};
  end
endmodule

module alu_share_arbiter #(
  parameter int unsigned FLAG_OWNER = 0,
  parameter int unsigned RESET_LAST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [2:0]  req0_op_i,
  input  logic [15:0] req0_a_i,
  input  logic [15:0] req0_b_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [2:0]  req1_op_i,
  input  logic [15:0] req1_a_i,
  input  logic [15:0] req1_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [15:0] rsp_data_o,
  output logic [2:0]  rsp_flags_o,
  input  logic        flush_i,
  output logic [2:0]  flag_reg_o
);
  localparam int unsigned DW  = 16;
  localparam int unsigned OPW = 3;
  localparam int unsigned FW  = 3;
  localparam logic OWNER_ID   = 1'(FLAG_OWNER);
  localparam logic LAST_RST   = 1'(RESET_LAST);

  localparam logic [OPW-1:0] OP_ADD = 3'd0;
  localparam logic [OPW-1:0] OP_SUB = 3'd1;
  localparam logic [OPW-1:0] OP_XOR = 3'd2;
  localparam logic [OPW-1:0] OP_SLL = 3'd4;
  localparam logic [OPW-1:0] OP_SRA = 3'd5;
  localparam logic [OPW-1:0] OP_ROR = 3'd6;

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            id_q, id_d;
  logic [DW-1:0]   data_q, data_d;
  logic [FW-1:0]   rflags_q, rflags_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [FW-1:0]   flag_q, flag_d;

  logic            can_accept;
  logic            grant;
  logic            win;
  logic [OPW-1:0]  alu_op;
  logic [DW-1:0]   alu_a, alu_b, alu_res;
  logic [FW-1:0]   alu_flags;

  // Combinational grant; no requester is acknowledged while reset is held.
  always_comb begin
    can_accept = (state_q == S_EMPTY) || rsp_ready_i;
    win        = 1'b0;
    if (req0_valid_i && req1_valid_i) win = ~last_q;
    else if (req1_valid_i)            win = 1'b1;
    grant        = rst_n && !flush_i && can_accept && (req0_valid_i || req1_valid_i);
    req0_ready_o = grant && !win;
    req1_ready_o = grant && win;
    alu_op       = win ? req1_op_i : req0_op_i;
    alu_a        = win ? req1_a_i  : req0_a_i;
    alu_b        = win ? req1_b_i  : req0_b_i;
  end

  alu16 u_alu (
    .op_i    (alu_op),
    .a_i     (alu_a),
    .b_i     (alu_b),
    .res_o   (alu_res),
    .flags_o (alu_flags)
  );

  // Buffer next-state, capture on grant, and flag write-back on owner handshake.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    data_d   = data_q;
    rflags_d = rflags_q;
    op_d     = op_q;
    flag_d   = flag_q;
    case (state_q)
      S_EMPTY: if (grant) state_d = S_FULL;
      S_FULL: begin
        if (flush_i)                     state_d = S_EMPTY;
        else if (rsp_ready_i && !grant)  state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
    if (grant) begin
      data_d   = alu_res;
      rflags_d = alu_flags;
      op_d     = alu_op;
      id_d     = win;
      last_d   = win;
    end
    if ((state_q == S_FULL) && rsp_ready_i && !flush_i && (id_q == OWNER_ID)) begin
      case (op_q)
        OP_ADD, OP_SUB:                 flag_d    = rflags_q;
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_d[1] = rflags_q[1];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      last_q   <= LAST_RST;
      id_q     <= 1'b0;
      data_q   <= '0;
      rflags_q <= '0;
      op_q     <= '0;
      flag_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      data_q   <= data_d;
      rflags_q <= rflags_d;
      op_q     <= op_d;
      flag_q   <= flag_d;
    end
  end

  assign rsp_valid_o = (state_q == S_FULL);
  assign rsp_id_o    = id_q;
  assign rsp_data_o  = data_q;
  assign rsp_flags_o = rflags_q;
  assign flag_reg_o  = flag_q;
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 16-bit ALU (3-bit opcode, {N,Z,V} flags) between two requesters: port 0 is the EX stage and port 1 is the auxiliary address/branch-target unit.
- Arbitrates round-robin and instantiates the ALU internally.
- Registers one result into a single-entry response buffer with valid/ready backpressure.
- Maintains the architectural flag register, updated per the ISA flag-write rules only by the owning requester.

Parameters:
- FLAG_OWNER, 0: requester ID whose accepted results update flag_reg. Legal values are 0 and 1.
- RESET_LAST, 1: reset value of the round-robin pointer. 1 means requester 0 wins the first tie.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  3  ALU opcode: 000 ADD, 001 SUB, 010 XOR, 011 RED, 100 SLL, 101 SRA, 110 ROR, 111 PADDSB.
- req0_a  in  16  operand 1.
- req0_b  in  16  operand 2. SLL, SRA and ROR use [3:0].
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as port 0, for requester 1.
- rsp_valid  out  1  response buffer full.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  ID of the requester that issued the response.
- rsp_data  out  16  registered ALU result.
- rsp_flags  out  3  registered raw ALU flags: [2]=N, [1]=Z, [0]=V.
- flush  in  1  synchronous drop of the buffered response.
- flag_reg  out  3  architectural flags: [2]=N, [1]=Z, [0]=V.

Behaviour:
- Reset (rst_n low, asynchronous) sets all of the following at once:
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flags=0.
  - flag_reg=3'b000.
  - last_grant=RESET_LAST.
  - req0_ready=0 and req1_ready=0 while reset is held.
- Reset during a pending response discards it, with no flag update.
- Buffer states:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- can_accept = EMPTY, or FULL with rsp_ready=1 (same-cycle drain and refill).
- Grant is combinational:
  - Only one requester valid: it is granted if can_accept.
  - Both valid: the requester other than last_grant wins.
  - reqN_ready=1 only for the granted requester, and only when can_accept and flush=0.
  - A non-granted requester must hold its valid and operands stable.
- On grant:
  - The ALU is driven from the winner's op/a/b.
  - At the clock edge, rsp_data, rsp_flags and rsp_id capture the ALU outputs and winner ID, and rsp_valid goes to 1.
  - last_grant updates to the winner ID.
  - Latency is 1 cycle, and throughput is 1 op/cycle when rsp_ready is held at 1.
- Transitions:
  - EMPTY→FULL on grant.
  - FULL→EMPTY on rsp_ready=1 with no grant.
  - FULL→FULL on drain+grant, or on stall (rsp_ready=0).
- last_grant changes only on a grant; idle cycles preserve it.
- flag_reg update happens on the response handshake (rsp_valid & rsp_ready) when rsp_id==FLAG_OWNER:
  - ADD, SUB: N, Z and V all written from rsp_flags.
  - XOR, SLL, SRA, ROR: Z written only; N and V held.
  - RED, PADDSB: no flag written.
  - The opcode is stored alongside the response to apply these rules.
- Responses from the non-owner never touch flag_reg.
- flush=1:
  - rsp_valid is cleared at the next edge, with no flag update even if rsp_ready=1.
  - No grant is issued that cycle.
  - last_grant is unchanged.
- Raw flags are as the ALU produces them: N and V are meaningful only for ADD/SUB, and Z is result==0.

Test Plan:
- Reset, then req0 ADD a=0x7FFF b=0x0001 with rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_data=0x8000, rsp_flags=3'b101; after handshake, flag_reg=3'b101.
- Owner does SUB 0x0005-0x0005, then XOR 0x00FF^0x0F00 → after SUB flag_reg=3'b010; after XOR (result 0x0FFF) flag_reg=3'b000. Then owner PADDSB producing 0 → flag_reg stays 3'b000.
- Both requesters valid for 4 cycles after reset with rsp_ready=1 → grants 0,1,0,1 and rsp_id follows one cycle later. Req1 ADD producing 0x8000 leaves flag_reg unchanged.
- rsp_ready=0 for 3 cycles with req0 valid → req0_ready=0 for all three and rsp_data held. On the cycle rsp_ready=1, req0_ready=1 (drain+refill) and rsp_valid stays 1.
- Flush with a full buffer and rsp_ready=1 on an owner SUB giving 0 → rsp_valid=0 next cycle, flag_reg unchanged, and no grant that cycle.
- Assert rst_n low mid-stall with a pending owner response → immediately rsp_valid=0 and flag_reg=0; after release, req1-only traffic is granted.
